dms_pfd: RTL and testbench
==========================

Name: dms_pfd

Overview:
- Clocked, sampled phase-frequency detector that drives the `up`/`down` control inputs of the CDR charge pump.
- Compares rising edges of the reference clock (`ref_in`) and the divided feedback clock (`fb_in`), both sampled on the system clock.
- Produces tri-state PFD pulses with an anti-deadzone overlap interval.
- Reports a signed per-comparison phase error (in clk cycles) for digital loop monitoring.

Parameters:
- RST_DLY, 2, cycles that up and down are held together (both=1) before clearing (anti-deadzone); legal range 1..15.
- ERR_W, 12, width of the signed `err_out`.
- LOCK_TOL, 4, maximum |err_out| counted as an in-lock comparison (used only with the optional feature).
- LOCK_CNT, 64, consecutive in-lock comparisons required to assert `lock` (used only with the optional feature).

Ports:
- clk  input  1  system sampling clock.
- rst  input  1  synchronous, active-high reset.
- ref_in  input  1  reference clock, asynchronous to clk.
- fb_in  input  1  feedback clock, asynchronous to clk.
- up  output  1  charge-pump source enable.
- down  output  1  charge-pump sink enable.
- err_out  output  ERR_W  signed phase error; positive means ref leads.
- err_vld  output  1  one-cycle strobe; err_out is valid when err_vld=1.
- lock  output  1  lock indicator; tied 0 when the optional feature is compiled out.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: up=0, down=0, err_out=0, err_vld=0, lock=0; state=IDLE; pending flags, error counter and lock counter cleared. Reset asserted mid-pulse clears everything on the next clk edge; no err_vld is emitted for the aborted comparison.
- Input path: each input goes through a 2-flop synchronizer, then rising-edge detect (sync2 & ~sync2_d).
- Latency: an input high at clk edge k registers as an edge at edge k+2. The up/down response is visible after edge k+3.
- State machine:
  - IDLE: up=0, down=0.
    - ref edge only → UP.
    - fb edge only → DN.
    - both edges in the same cycle → RST, err=0.
  - UP: up=1, down=0. Error counter increments each cycle, saturating at +(2^(ERR_W-1)-1).
    - Further ref edges are ignored (frequency-detect behaviour).
    - fb edge → RST.
  - DN: mirror of UP. down=1, counter decrements, saturating at -(2^(ERR_W-1)-1).
    - Further fb edges are ignored.
    - ref edge → RST.
  - RST: up=1, down=1 for exactly RST_DLY cycles, then → IDLE (or to the pending target).
- Error reporting: on the transition into RST, err_out is loaded with the counter value and err_vld=1 for one cycle. The counter clears; err_out holds until the next strobe.
- Edges during RST:
  - Each edge arriving during RST sets a per-input pending flag.
  - On exit, pending ref only → UP; pending fb only → DN; both → RST again with err=0 and err_vld=1.
  - Pending flags clear on exit.
- up and down come directly from state flops. There are no combinational paths from inputs to outputs.

Optional Feature:
- Macro: DMS_PFD_LOCK_DET_EN.
- When defined:
  - Lock counter increments on each err_vld with |err_out| ≤ LOCK_TOL, saturating at LOCK_CNT.
  - Any err_vld with |err_out| > LOCK_TOL clears the counter and deasserts lock on the next cycle.
  - lock=1 while the counter equals LOCK_CNT.
- When undefined: no lock counter logic; lock is constant 0.

Decomposition:
- Package dms_pkg holds:
  - pfd_state_t enum {IDLE, UP, DN, RST}.
  - Function for saturating signed increment/decrement.
  - Default constants for RST_DLY and ERR_W.
- Sub-module dms_edge_sync: 2-flop synchronizer plus rising-edge pulse. Instantiated twice, once each for ref_in and fb_in.

Test Plan:
1. Reset, then ref_in and fb_in rise in the same clk cycle → up=down=1 for 2 cycles, no single-sided pulse; err_vld with err_out=0.
2. ref_in rises 10 clk cycles before fb_in → up=1 alone for 10 cycles, then up=down=1 for 2 cycles; err_out=+10.
3. fb_in leads by 7 cycles → down-only pulse of 7 cycles; err_out=-7.
4. Three ref edges before one fb edge (ERR_W=4, ref leads >20 cycles) → up stays high, no extra strobes; err_out saturates at +7.
5. fb edge lands during the RST window (RST_DLY=4) after a ref-led comparison → after RST, DN state entered; next err_vld reports the correct negative count.
6. With DMS_PFD_LOCK_DET_EN and LOCK_CNT=4: 4 comparisons at err=±2 → lock=1; next comparison err=+9 → lock=0 on the following cycle. Assert rst mid-UP → up=0 next cycle and no err_vld.

Source files
------------

// File: rtl/dms_pfd_pkg.sv
// Shared types, default constants and saturating counter helper for the dms_pfd
// sampled phase-frequency detector.
package dms_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DN   = 2'd2,
    RST  = 2'd3
  } pfd_state_t;

  localparam int unsigned RST_DLY_DEF  = 32'd2;
  localparam int unsigned ERR_W_DEF    = 32'd12;
  localparam int unsigned LOCK_TOL_DEF = 32'd4;
  localparam int unsigned LOCK_CNT_DEF = 32'd64;

  // Step a w-bit signed value by +/-1, clamped symmetrically at +/-(2^(w-1)-1).
  function automatic logic signed [31:0] sat_step(input logic signed [31:0] val,
                                                  input logic              inc,
                                                  input int unsigned       w);
    logic signed [31:0] lim;
    lim = (32'sd1 <<< (w - 32'd1)) - 32'sd1;
    if (inc) begin
      return (val >= lim) ? lim : (val + 32'sd1);
    end else begin
      return (val <= -lim) ? -lim : (val - 32'sd1);
    end
  endfunction

endpackage

// File: rtl/dms_pfd_if.sv
// Signal bundle between the PFD and its environment: clock inputs to compare,
// charge-pump controls and phase-error monitor outputs.
interface dms_pfd_if #(
  parameter int unsigned ERR_W = 32'd12
);
  logic                    ref_in;
  logic                    fb_in;
  logic                    up;
  logic                    down;
  logic signed [ERR_W-1:0] err_out;
  logic                    err_vld;
  logic                    lock;

  modport master (
    output ref_in, fb_in,
    input  up, down, err_out, err_vld, lock
  );

  modport slave (
    input  ref_in, fb_in,
    output up, down, err_out, err_vld, lock
  );
endinterface

// File: rtl/dms_edge_sync.sv
// Two-flop synchronizer followed by a registered rising-edge pulse; an input
// high at edge k produces a one-cycle pulse visible after edge k+2.
module dms_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic d_in,
  output logic edge_o
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic s2_dly_q, s2_dly_d;
  logic edge_q, edge_d;

  // Next-state for the synchronizer chain and edge pulse.
  always_comb begin
    s1_d     = d_in;
    s2_d     = s1_q;
    s2_dly_d = s2_q;
    edge_d   = s2_q & ~s2_dly_q;
  end

  // Synchronizer and edge registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      s2_dly_q <= 1'b0;
      edge_q   <= 1'b0;
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      s2_dly_q <= s2_dly_d;
      edge_q   <= edge_d;
    end
  end

  assign edge_o = edge_q;

endmodule

// File: rtl/dms_pfd.sv
// Clocked tri-state phase-frequency detector with anti-deadzone overlap and a
// signed phase-error monitor. Define DMS_PFD_LOCK_DET_EN to build the lock detector.
module dms_pfd
  import dms_pkg::*;
#(
  parameter int unsigned RST_DLY  = RST_DLY_DEF,
  parameter int unsigned ERR_W    = ERR_W_DEF,
  parameter int unsigned LOCK_TOL = LOCK_TOL_DEF,
  parameter int unsigned LOCK_CNT = LOCK_CNT_DEF
) (
  input logic       clk,
  input logic       rst,
  dms_pfd_if.slave  pfd
);

  localparam logic [3:0] RST_LAST = 4'(RST_DLY - 32'd1);

  logic ref_edge;
  logic fb_edge;

  dms_edge_sync u_ref_sync (
    .clk    (clk),
    .rst    (rst),
    .d_in   (pfd.ref_in),
    .edge_o (ref_edge)
  );

  dms_edge_sync u_fb_sync (
    .clk    (clk),
    .rst    (rst),
    .d_in   (pfd.fb_in),
    .edge_o (fb_edge)
  );

  pfd_state_t              state_q, state_d;
  logic signed [ERR_W-1:0] cnt_q, cnt_d;
  logic signed [ERR_W-1:0] err_q, err_d;
  logic                    vld_q, vld_d;
  logic [3:0]              rcnt_q, rcnt_d;
  logic                    pend_ref_q, pend_ref_d;
  logic                    pend_fb_q, pend_fb_d;
  logic                    up_q, up_d;
  logic                    down_q, down_d;

  logic signed [31:0]      cnt_ext;
  logic signed [31:0]      inc_ext;
  logic signed [31:0]      dec_ext;
  logic signed [ERR_W-1:0] cnt_inc;
  logic signed [ERR_W-1:0] cnt_dec;
  logic                    pref_any;
  logic                    pfb_any;

  // Saturating neighbours of the running phase counter.
  always_comb begin
    cnt_ext = {{(32 - ERR_W){cnt_q[ERR_W-1]}}, cnt_q};
    inc_ext = sat_step(cnt_ext, 1'b1, ERR_W);
    dec_ext = sat_step(cnt_ext, 1'b0, ERR_W);
    cnt_inc = $signed(inc_ext[ERR_W-1:0]);
    cnt_dec = $signed(dec_ext[ERR_W-1:0]);
  end

  // Detector state machine; the cycle that closes a comparison is counted.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    vld_d      = 1'b0;
    rcnt_d     = rcnt_q;
    pend_ref_d = pend_ref_q;
    pend_fb_d  = pend_fb_q;
    pref_any   = pend_ref_q | ref_edge;
    pfb_any    = pend_fb_q | fb_edge;

    case (state_q)
      IDLE: begin
        if (ref_edge && fb_edge) begin
          state_d = RST;
          err_d   = '0;
          vld_d   = 1'b1;
          rcnt_d  = 4'd0;
        end else if (ref_edge) begin
          state_d = UP;
        end else if (fb_edge) begin
          state_d = DN;
        end else begin
          state_d = IDLE;
        end
      end
      UP: begin
        if (fb_edge) begin
          state_d = RST;
          err_d   = cnt_inc;
          vld_d   = 1'b1;
          cnt_d   = '0;
          rcnt_d  = 4'd0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      DN: begin
        if (ref_edge) begin
          state_d = RST;
          err_d   = cnt_dec;
          vld_d   = 1'b1;
          cnt_d   = '0;
          rcnt_d  = 4'd0;
        end else begin
          cnt_d = cnt_dec;
        end
      end
      RST: begin
        // Edges landing in the overlap window are remembered, including the exit cycle.
        if (rcnt_q == RST_LAST) begin
          rcnt_d     = 4'd0;
          pend_ref_d = 1'b0;
          pend_fb_d  = 1'b0;
          if (pref_any && pfb_any) begin
            state_d = RST;
            err_d   = '0;
            vld_d   = 1'b1;
          end else if (pref_any) begin
            state_d = UP;
          end else if (pfb_any) begin
            state_d = DN;
          end else begin
            state_d = IDLE;
          end
        end else begin
          rcnt_d     = rcnt_q + 4'd1;
          pend_ref_d = pref_any;
          pend_fb_d  = pfb_any;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    up_d   = (state_d == UP) || (state_d == RST);
    down_d = (state_d == DN) || (state_d == RST);
  end

  // Detector registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      err_q      <= '0;
      vld_q      <= 1'b0;
      rcnt_q     <= 4'd0;
      pend_ref_q <= 1'b0;
      pend_fb_q  <= 1'b0;
      up_q       <= 1'b0;
      down_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      vld_q      <= vld_d;
      rcnt_q     <= rcnt_d;
      pend_ref_q <= pend_ref_d;
      pend_fb_q  <= pend_fb_d;
      up_q       <= up_d;
      down_q     <= down_d;
    end
  end

  assign pfd.up      = up_q;
  assign pfd.down    = down_q;
  assign pfd.err_out = err_q;
  assign pfd.err_vld = vld_q;

`ifdef DMS_PFD_LOCK_DET_EN
  localparam int unsigned     LCW        = $clog2(LOCK_CNT + 32'd1);
  localparam logic [LCW-1:0]  LOCK_CNT_V = LCW'(LOCK_CNT);
  localparam logic [ERR_W-1:0] LOCK_TOL_V = ERR_W'(LOCK_TOL);

  logic [LCW-1:0]   lcnt_q, lcnt_d;
  logic             lock_q, lock_d;
  logic [ERR_W-1:0] err_abs;

  // Consecutive in-tolerance comparison counter; err_q never reaches -2^(ERR_W-1).
  always_comb begin
    err_abs = err_q[ERR_W-1] ? ERR_W'(-err_q) : ERR_W'(err_q);
    if (vld_q) begin
      if (err_abs <= LOCK_TOL_V) begin
        lcnt_d = (lcnt_q == LOCK_CNT_V) ? lcnt_q : (lcnt_q + LCW'(1));
      end else begin
        lcnt_d = '0;
      end
    end else begin
      lcnt_d = lcnt_q;
    end
    lock_d = (lcnt_d == LOCK_CNT_V);
  end

  // Lock detector registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      lcnt_q <= '0;
      lock_q <= 1'b0;
    end else begin
      lcnt_q <= lcnt_d;
      lock_q <= lock_d;
    end
  end

  assign pfd.lock = lock_q;
`else
  assign pfd.lock = 1'b0;
`endif

endmodule

// File: tb/tb_dms_pfd.sv
// Directed bench for dms_pfd: two instances (RST_DLY=2/ERR_W=12 and RST_DLY=4/ERR_W=4)
// share the same ref/fb stimulus and are scored against hand-computed expectations.
module tb_dms_pfd;

  logic clk = 1'b0;
  logic rst;
  logic ref_drv;
  logic fb_drv;

  always #5 clk = ~clk;

  dms_pfd_if #(.ERR_W(12)) ifa ();
  dms_pfd_if #(.ERR_W(4))  ifb ();

  assign ifa.ref_in = ref_drv;
  assign ifa.fb_in  = fb_drv;
  assign ifb.ref_in = ref_drv;
  assign ifb.fb_in  = fb_drv;

  dms_pfd #(.RST_DLY(2), .ERR_W(12), .LOCK_TOL(4), .LOCK_CNT(4)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .pfd (ifa.slave)
  );

  dms_pfd #(.RST_DLY(4), .ERR_W(4), .LOCK_TOL(4), .LOCK_CNT(4)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .pfd (ifb.slave)
  );

`ifdef DMS_PFD_LOCK_DET_EN
  localparam int LOCK_ON = 1;
`else
  localparam int LOCK_ON = 0;
`endif

  int checks = 0;
  int errors = 0;

  int up_only[2], dn_only[2], both_on[2], nstb[2];
  int err_last[2], err_prev[2], lock_after[2];
  bit stb_dly[2];
  int b_up[2], b_dn[2], b_both[2], b_stb[2];
  int rdly[2] = '{2, 4};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic mon(input int d, input logic u, input logic dn, input logic v,
                     input int e, input logic lk);
    if (u && !dn) up_only[d]++;
    if (!u && dn) dn_only[d]++;
    if (u && dn)  both_on[d]++;
    if (stb_dly[d]) lock_after[d] = int'(lk);
    stb_dly[d] = v;
    if (v) begin
      nstb[d]++;
      err_prev[d] = err_last[d];
      err_last[d] = e;
    end
  endtask

  // Output observer, sampling 1 time unit after each rising clock edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      mon(0, ifa.up, ifa.down, ifa.err_vld, int'($signed(ifa.err_out)), ifa.lock);
      mon(1, ifb.up, ifb.down, ifb.err_vld, int'($signed(ifb.err_out)), ifb.lock);
    end
  end

  task automatic snap();
    for (int d = 0; d < 2; d++) begin
      b_up[d]   = up_only[d];
      b_dn[d]   = dn_only[d];
      b_both[d] = both_on[d];
      b_stb[d]  = nstb[d];
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_run(input string tag, input int d, input int e_stb, input int e_err,
                           input int e_up, input int e_dn, input int e_both);
    chk($sformatf("%s[%0d].strobes", tag, d), nstb[d] - b_stb[d], e_stb);
    chk($sformatf("%s[%0d].err", tag, d), err_last[d], e_err);
    chk($sformatf("%s[%0d].up_only", tag, d), up_only[d] - b_up[d], e_up);
    chk($sformatf("%s[%0d].dn_only", tag, d), dn_only[d] - b_dn[d], e_dn);
    chk($sformatf("%s[%0d].both", tag, d), both_on[d] - b_both[d], e_both);
  endtask

  task automatic run_cmp(input int lead);
    if (lead >= 0) begin
      ref_drv = 1'b1;
      tick(lead);
      fb_drv = 1'b1;
    end else begin
      fb_drv = 1'b1;
      tick(-lead);
      ref_drv = 1'b1;
    end
    tick(16);
    ref_drv = 1'b0;
    fb_drv  = 1'b0;
    tick(6);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, ".a.up"},      int'(ifa.up),      0);
    chk({tag, ".a.down"},    int'(ifa.down),    0);
    chk({tag, ".a.err_out"}, int'(ifa.err_out), 0);
    chk({tag, ".a.err_vld"}, int'(ifa.err_vld), 0);
    chk({tag, ".a.lock"},    int'(ifa.lock),    0);
    chk({tag, ".b.up"},      int'(ifb.up),      0);
    chk({tag, ".b.down"},    int'(ifb.down),    0);
    chk({tag, ".b.err_out"}, int'(ifb.err_out), 0);
  endtask

  typedef struct {
    int lead;
    int err_a;
    int err_b;
    int exp_up;
    int exp_dn;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{0,   0,  0,  0, 0};
    vecs[1] = '{10, 10,  7, 10, 0};
    vecs[2] = '{-7, -7, -7,  0, 7};
    vecs[3] = '{1,   1,  1,  1, 0};
    vecs[4] = '{-3, -3, -3,  0, 3};
    vecs[5] = '{5,   5,  5,  5, 0};

    rst     = 1'b1;
    ref_drv = 1'b0;
    fb_drv  = 1'b0;
    tick(3);
    check_idle("reset");
    rst = 1'b0;
    tick(3);
    check_idle("post_reset");

    // Single comparisons at several leads, both polarities, including simultaneous edges.
    for (int i = 0; i < 6; i++) begin
      snap();
      run_cmp(vecs[i].lead);
      check_run($sformatf("vec%0d", i), 0, 1, vecs[i].err_a, vecs[i].exp_up, vecs[i].exp_dn, rdly[0]);
      check_run($sformatf("vec%0d", i), 1, 1, vecs[i].err_b, vecs[i].exp_up, vecs[i].exp_dn, rdly[1]);
    end

    // Three ref edges before fb (25-cycle lead): extra ref edges ignored, 4-bit counter saturates.
    snap();
    ref_drv = 1'b1; tick(3);
    ref_drv = 1'b0; tick(3);
    ref_drv = 1'b1; tick(3);
    ref_drv = 1'b0; tick(3);
    ref_drv = 1'b1; tick(13);
    fb_drv  = 1'b1; tick(16);
    ref_drv = 1'b0;
    fb_drv  = 1'b0;
    tick(6);
    check_run("multi_ref", 0, 1, 25, 25, 0, 2);
    check_run("multi_ref", 1, 1, 7, 25, 0, 4);

    // Second fb edge inside the overlap window: DN follows and the next error counts from exit.
    snap();
    ref_drv = 1'b1; tick(3);
    fb_drv  = 1'b1; tick(1);
    fb_drv  = 1'b0; tick(1);
    fb_drv  = 1'b1; tick(1);
    ref_drv = 1'b0; tick(7);
    ref_drv = 1'b1; tick(16);
    ref_drv = 1'b0;
    fb_drv  = 1'b0;
    tick(6);
    chk("pend_fb[0].first_err", err_prev[0], 3);
    chk("pend_fb[1].first_err", err_prev[1], 3);
    check_run("pend_fb", 0, 2, -8, 3, 8, 4);
    check_run("pend_fb", 1, 2, -6, 3, 6, 8);

    // Lock detection over four small errors, then loss on one large error.
    rst = 1'b1; tick(2);
    rst = 1'b0; tick(3);
    run_cmp(2);
    run_cmp(-2);
    run_cmp(2);
    chk("lock.after3.a", lock_after[0], 0);
    chk("lock.after3.b", lock_after[1], 0);
    run_cmp(-2);
    chk("lock.after4.a", lock_after[0], LOCK_ON);
    chk("lock.after4.b", lock_after[1], LOCK_ON);
    chk("lock.hold.a", int'(ifa.lock), LOCK_ON);
    run_cmp(9);
    chk("lock.big_err.a", err_last[0], 9);
    chk("lock.lost.a", lock_after[0], 0);
    chk("lock.lost.b", lock_after[1], 0);
    chk("lock.final.a", int'(ifa.lock), 0);

    // Reset while UP is active: outputs clear at once and the comparison produces no strobe.
    snap();
    ref_drv = 1'b1; tick(6);
    ref_drv = 1'b0; tick(3);
    chk("mid_up.before.a.up", int'(ifa.up), 1);
    chk("mid_up.before.b.up", int'(ifb.up), 1);
    rst = 1'b1; tick(1);
    chk("mid_up.rst.a.up", int'(ifa.up), 0);
    chk("mid_up.rst.b.up", int'(ifb.up), 0);
    rst = 1'b0; tick(10);
    chk("mid_up.strobes.a", nstb[0] - b_stb[0], 0);
    chk("mid_up.strobes.b", nstb[1] - b_stb[1], 0);
    check_idle("mid_up.after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
